fhn_spike_encoder: RTL
======================

Name: fhn_spike_encoder

Overview:
- Consumes the fixed-point membrane-voltage stream v_out produced by the FHN neuron core, one sample per v_valid.
- Detects spikes using hysteresis thresholds and encodes each one as an event record: timestamp, peak voltage and width in samples.
- Queues events in a small first-word-fall-through (FWFT) FIFO behind a valid/ready handshake.
- Replaces software post-processing of logged voltage traces with in-hardware spike extraction.

Parameters:
- DATA_W, 16, voltage sample width, signed, Q(DATA_W-FRC_BITS).FRC_BITS format
- FRC_BITS, 12, fractional bits; 1.0 = 4096
- TH_HI, 2048, upper threshold (0.5); crossing at or above it starts a spike
- TH_LO, -2048, lower threshold (-0.5); falling to or below it ends a spike and re-arms
- TS_W, 32, sample-counter / timestamp width
- WID_W, 16, spike-width field width
- MIN_WIDTH, 4, spikes shorter than this many samples are discarded as glitches
- FIFO_DEPTH, 8, event FIFO entries; power of two, at least 2

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- en  in  1  detection enable; when 0, samples are ignored and all state is held
- v_in  in  DATA_W  signed voltage sample from the neuron core
- v_valid  in  1  v_in is valid this cycle
- ev_valid  out  1  event available at FIFO head
- ev_ready  in  1  consumer accepts the head event
- ev_ts  out  TS_W  sample index of the first sample at or above TH_HI
- ev_peak  out  DATA_W  maximum v_in observed during the spike
- ev_width  out  WID_W  number of samples from the onset sample to the sample before the end sample
- ev_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- drop_cnt  out  8  count of events lost to a full FIFO; saturates at 255
- overflow  out  1  sticky; set on the first drop, cleared only by reset
- state_o  out  2  current FSM state: 0=INIT, 1=ARMED, 2=SPIKE

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to INIT.
  - Sample counter, FIFO pointers, ev_level, drop_cnt, overflow and ev_valid are all 0.
  - ev_ts, ev_peak and ev_width read 0.
- Accepted sample: v_valid=1 and en=1 at a rising edge. The sample counter increments by 1 on every accepted sample and wraps modulo 2^TS_W. A sample's index is the counter value before that increment.
- Comparisons are signed, full DATA_W. No scaling or rounding is applied anywhere.
- FSM, evaluated on accepted samples only:
  - INIT -> ARMED when v_in <= TH_LO. This prevents a false event when starting mid-spike. Otherwise stay in INIT.
  - ARMED -> SPIKE when v_in >= TH_HI. Latch ts = sample index, peak = v_in, width = 1.
  - SPIKE, v_in > TH_LO: peak = max(peak, v_in); width += 1, saturating at 2^WID_W-1.
  - SPIKE, v_in <= TH_LO: if width >= MIN_WIDTH, push {ts, peak, width}; go to ARMED either way. The end sample is not counted in width.
  - Values strictly between the thresholds never change state.
- Event latency: a push on rising edge N makes the event visible on the outputs, with ev_valid=1, after edge N.
- FIFO rules:
  - FWFT. Outputs are driven from registered storage.
  - Pop happens when ev_valid && ev_ready at an edge.
  - Simultaneous push and pop while full: both succeed and the level is unchanged.
  - Push while full without a pop: the event is dropped, drop_cnt += 1 (saturating), overflow=1.
  - Pop while empty is ignored.
  - ev_ts, ev_peak and ev_width stay stable while ev_valid=1 and ev_ready=0.
- en=0: samples are not counted, the FSM is frozen and no push occurs. The FIFO still drains normally.
- Reset asserted mid-spike discards the partial spike and all queued events.

Decomposition:
- Package fhn_pkg:
  - FRC_BITS, DATA_W
  - Q-format constant ONE_Q = 4096
  - FSM state enum
  - Packed event struct {ts, peak, width}
- Sub-module spike_event_fifo: a generic FWFT FIFO, parameterised by width and depth, with push/pop and level outputs and async active-low reset.
- The FSM, sample counter and drop accounting live in the top module.

Test Plan:
1. Reset then hold: v_in=0 with valid every cycle -> state_o stays 0, ev_valid=0, counter advances.
2. Basic spike:
   - Stimulus: -4096 x3, 6144 x5 (peak 8000 in the 3rd of the five), then -4096.
   - Required: one event with ts=3, peak=8000, width=5. ev_valid is high the cycle after the -4096 sample.
3. Glitch and hysteresis:
   - Stimulus: arm, then 3000 x3, then -3000.
   - Required: no event (width 3 < MIN_WIDTH).
   - Values of 0 between the thresholds during a spike extend width and do not end it.
4. Start above threshold: first samples at 6000 x10 -> state stays INIT, no event until a sample <= -2048 arms the FSM.
5. Backpressure and overflow:
   - Stimulus: ev_ready=0, 10 valid spikes.
   - Required: ev_level=8, drop_cnt=2, overflow=1, head event unchanged.
   - Then with ev_ready=1: 8 events drain in order and overflow stays 1.
6. Enable gating and reset:
   - en=0 mid-spike for 50 cycles -> the event's width excludes those cycles.
   - rst pulsed low mid-spike -> all outputs return to 0 and state_o=0 immediately (asynchronously).

Source files
------------

// File: rtl/fhn_pkg.sv
// ============================================================================
// Module   : fhn_pkg
// Brief    : Shared Q-format constants, FSM state encoding and event record
// Revision : 1.0
// ============================================================================
`default_nettype none

package fhn_pkg;

    localparam int DATA_W   = 16;
    localparam int FRC_BITS = 12;
    localparam int TS_W     = 32;
    localparam int WID_W    = 16;

    localparam logic signed [DATA_W-1:0] ONE_Q = 16'sd4096;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_ARMED = 2'd1,
        ST_SPIKE = 2'd2
    } fhn_state_t;

    typedef struct packed {
        logic        [TS_W-1:0]   ts;
        logic signed [DATA_W-1:0] peak;
        logic        [WID_W-1:0]  width;
    } fhn_event_t;

endpackage

`default_nettype wire

// File: rtl/spike_event_fifo.sv
// ============================================================================
// Module   : spike_event_fifo
// Brief    : Generic first-word-fall-through FIFO with occupancy output
// Revision : 1.0
// ============================================================================
`default_nettype none

module spike_event_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_din,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_valid,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [LW-1:0]    r_level;
    logic             w_empty;
    logic             w_full;
    logic             w_do_pop;
    logic             w_do_push;

    assign w_empty   = (r_level == '0);
    assign w_full    = (r_level == LW'(DEPTH));
    assign w_do_pop  = i_pop & ~w_empty;
    // A pop in the same cycle frees the head slot, so a full FIFO still accepts.
    assign w_do_push = i_push & (~w_full | w_do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= i_din;
    end

    assign o_dout  = w_empty ? '0 : r_mem[r_rptr];
    assign o_valid = ~w_empty;
    assign o_full  = w_full;
    assign o_level = r_level;

endmodule

`default_nettype wire

// File: rtl/fhn_spike_encoder.sv
// ============================================================================
// Module   : fhn_spike_encoder
// Brief    : Hysteresis spike detector producing {ts, peak, width} events
// Revision : 1.0
// ============================================================================
`default_nettype none

module fhn_spike_encoder #(
    parameter int                       DATA_W     = 16,
    parameter int                       FRC_BITS   = 12,
    parameter logic signed [DATA_W-1:0] TH_HI      = DATA_W'(1 << (FRC_BITS - 1)),
    parameter logic signed [DATA_W-1:0] TH_LO      = -(DATA_W'(1 << (FRC_BITS - 1))),
    parameter int                       TS_W       = 32,
    parameter int                       WID_W      = 16,
    parameter int                       MIN_WIDTH  = 4,
    parameter int                       FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic signed [DATA_W-1:0]      v_in,
    input  logic                          v_valid,
    output logic                          ev_valid,
    input  logic                          ev_ready,
    output logic        [TS_W-1:0]        ev_ts,
    output logic signed [DATA_W-1:0]      ev_peak,
    output logic        [WID_W-1:0]       ev_width,
    output logic [$clog2(FIFO_DEPTH):0]   ev_level,
    output logic        [7:0]             drop_cnt,
    output logic                          overflow,
    output logic        [1:0]             state_o
);

    import fhn_pkg::*;

    localparam int          EW          = TS_W + DATA_W + WID_W;
    localparam logic [WID_W-1:0] C_MIN_WIDTH = WID_W'(MIN_WIDTH);

    fhn_state_t               r_state;
    fhn_state_t               w_state_nxt;
    logic        [TS_W-1:0]   r_cnt;
    logic        [TS_W-1:0]   r_ts;
    logic signed [DATA_W-1:0] r_peak;
    logic        [WID_W-1:0]  r_width;
    logic        [7:0]        r_drop;
    logic                     r_ovf;
    logic                     w_acc;
    logic                     w_hi;
    logic                     w_lo;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_full;
    logic        [EW-1:0]     w_dout;

    assign w_acc = v_valid & en;
    assign w_hi  = (v_in >= TH_HI);
    assign w_lo  = (v_in <= TH_LO);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_INIT;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        if (w_acc) begin
            case (r_state)
                ST_INIT:  if (w_lo) w_state_nxt = ST_ARMED;
                ST_ARMED: if (w_hi) w_state_nxt = ST_SPIKE;
                ST_SPIKE: begin
                    if (w_lo) begin
                        w_state_nxt = ST_ARMED;
                        w_push      = (r_width >= C_MIN_WIDTH);
                    end
                end
                default:  w_state_nxt = ST_INIT;
            endcase
        end
    end

    // The end sample is not part of the spike, so width/peak only move while above TH_LO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_ts    <= '0;
            r_peak  <= '0;
            r_width <= '0;
        end else if (w_acc) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_state == ST_ARMED && w_hi) begin
                r_ts    <= r_cnt;
                r_peak  <= v_in;
                r_width <= WID_W'(1);
            end else if (r_state == ST_SPIKE && !w_lo) begin
                if (v_in > r_peak) r_peak <= v_in;
                if (r_width != '1) r_width <= r_width + 1'b1;
            end
        end
    end

    assign w_pop = ev_valid & ev_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_drop <= '0;
            r_ovf  <= 1'b0;
        end else if (w_push && w_full && !w_pop) begin
            r_ovf <= 1'b1;
            if (r_drop != 8'hFF) r_drop <= r_drop + 1'b1;
        end
    end

    spike_event_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   ({r_ts, r_peak, r_width}),
        .i_pop   (w_pop),
        .o_dout  (w_dout),
        .o_valid (ev_valid),
        .o_full  (w_full),
        .o_level (ev_level)
    );

    assign {ev_ts, ev_peak, ev_width} = w_dout;
    assign drop_cnt = r_drop;
    assign overflow = r_ovf;
    assign state_o  = r_state;

endmodule

`default_nettype wire
